// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment message scanner:
// display modes, named glyph codes and the glyph-to-segment decoder.
package seg_disp_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;
  localparam logic [1:0] MODE_BLANK  = 2'd3;

  localparam logic [3:0] GLY_P     = 4'hA;
  localparam logic [3:0] GLY_E     = 4'hB;
  localparam logic [3:0] GLY_N     = 4'hC;
  localparam logic [3:0] GLY_C     = 4'hD;
  localparam logic [3:0] GLY_DASH  = 4'hE;
  localparam logic [3:0] GLY_BLANK = 4'hF;

  // Returns {g,f,e,d,c,b,a} with a lit segment = 1.
  function automatic logic [6:0] glyph_to_seg(input logic [3:0] code);
    case (code)
      4'h0:      return 7'h3F;
      4'h1:      return 7'h06;
      4'h2:      return 7'h5B;
      4'h3:      return 7'h4F;
      4'h4:      return 7'h66;
      4'h5:      return 7'h6D;
      4'h6:      return 7'h7D;
      4'h7:      return 7'h07;
      4'h8:      return 7'h7F;
      4'h9:      return 7'h6F;
      GLY_P:     return 7'h73;
      GLY_E:     return 7'h79;
      GLY_N:     return 7'h54;
      GLY_C:     return 7'h39;
      GLY_DASH:  return 7'h40;
      default:   return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing: prescaler, digit index, blink phase and scroll offset.
// index/blink_on/offset are the values for the slot that begins at the next edge.
module seg_scan_timer #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 1000,
  parameter int BLINK_FRAMES  = 64,
  parameter int SCROLL_FRAMES = 128,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scroll_en,
  input  logic             commit,
  output logic             slot_tick,
  output logic             frame_tick,
  output logic [IDX_W-1:0] index,
  output logic             blink_on,
  output logic [IDX_W-1:0] offset
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [PS_W-1:0]  ps_q, ps_nxt;
  logic [IDX_W-1:0] index_q;
  logic [BL_W-1:0]  blink_cnt_q, blink_cnt_nxt;
  logic             blink_q;
  logic [SC_W-1:0]  scroll_cnt_q, scroll_cnt_nxt;
  logic [IDX_W-1:0] offset_q;

  assign slot_tick  = (ps_q == PS_W'(PRESCALE - 1));
  assign frame_tick = slot_tick && (index_q == IDX_W'(NUM_DIGITS - 1));

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    ps_nxt         = slot_tick ? '0 : ps_q + PS_W'(1);
    index          = index_q;
    blink_cnt_nxt  = blink_cnt_q;
    blink_on       = blink_q;
    scroll_cnt_nxt = scroll_cnt_q;
    offset         = offset_q;

    if (slot_tick)
      index = frame_tick ? '0 : index_q + IDX_W'(1);

    if (frame_tick) begin
      if (blink_cnt_q == BL_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt = '0;
        blink_on      = ~blink_q;
      end else begin
        blink_cnt_nxt = blink_cnt_q + BL_W'(1);
      end
    end

    // A fresh message or leaving scroll mode restarts the scroll from digit 0.
    if (!scroll_en || commit) begin
      scroll_cnt_nxt = '0;
      offset         = '0;
    end else if (frame_tick) begin
      if (scroll_cnt_q == SC_W'(SCROLL_FRAMES - 1)) begin
        scroll_cnt_nxt = '0;
        offset = (offset_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : offset_q + IDX_W'(1);
      end else begin
        scroll_cnt_nxt = scroll_cnt_q + SC_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q         <= '0;
      index_q      <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b1;
      scroll_cnt_q <= '0;
      offset_q     <= '0;
    end else begin
      ps_q         <= ps_nxt;
      index_q      <= index;
      blink_cnt_q  <= blink_cnt_nxt;
      blink_q      <= blink_on;
      scroll_cnt_q <= scroll_cnt_nxt;
      offset_q     <= offset;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment message scanner with tear-free message loading
// and static, blink, scroll-left and blank rendering.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int                      NUM_DIGITS    = 4,
  parameter int                      PRESCALE      = 1000,
  parameter int                      BLINK_FRAMES  = 64,
  parameter int                      SCROLL_FRAMES = 128,
  parameter logic [4*NUM_DIGITS-1:0] INIT_MSG      = 16'hCBA0,
  parameter bit                      COM_ACT_HIGH  = 1'b1,
  parameter bit                      SEG_ACT_HIGH  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   msg_in,
  input  logic [1:0]                mode,
  output logic [NUM_DIGITS-1:0]     com,
  output logic [6:0]                seg,
  output logic                      load_pending,
  output logic                      frame_tick
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam int                    MSG_W    = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] COM_INIT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [6:0]            SEG_INIT = glyph_to_seg(INIT_MSG[3:0]);

  logic             slot_tick;
  logic             blink_on;
  logic             commit;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] offset;
  logic [MSG_W-1:0] msg_q, shadow_q, msg_nxt;
  int               digit_sel;
  logic [3:0]       code;
  logic [6:0]       seg_raw;
  logic [NUM_DIGITS-1:0] com_raw;

  seg_scan_timer #(
    .NUM_DIGITS    (NUM_DIGITS),
    .PRESCALE      (PRESCALE),
    .BLINK_FRAMES  (BLINK_FRAMES),
    .SCROLL_FRAMES (SCROLL_FRAMES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .scroll_en  (mode == MODE_SCROLL),
    .commit     (commit),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick),
    .index      (index),
    .blink_on   (blink_on),
    .offset     (offset)
  );

  // Messages only switch at the frame boundary; a load on that very cycle goes straight in.
  assign commit = frame_tick && (load || load_pending);

  always_comb begin
    msg_nxt = msg_q;
    if (frame_tick) begin
      if (load)              msg_nxt = msg_in;
      else if (load_pending) msg_nxt = shadow_q;
    end
  end

  // Render the slot that starts at the next edge from the post-edge message and timer state.
  always_comb begin
    digit_sel = int'(index) + int'(offset);
    if (digit_sel >= NUM_DIGITS) digit_sel = digit_sel - NUM_DIGITS;
    code = GLY_BLANK;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (d == digit_sel) code = msg_nxt[4*d +: 4];

    case (mode)
      MODE_STATIC, MODE_SCROLL: seg_raw = glyph_to_seg(code);
      MODE_BLINK:               seg_raw = blink_on ? glyph_to_seg(code) : 7'h00;
      default:                  seg_raw = 7'h00;
    endcase

    com_raw = COM_INIT << index;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q        <= INIT_MSG;
      shadow_q     <= INIT_MSG;
      load_pending <= 1'b0;
      com          <= COM_ACT_HIGH ? COM_INIT : ~COM_INIT;
      seg          <= SEG_ACT_HIGH ? SEG_INIT : ~SEG_INIT;
    end else begin
      msg_q <= msg_nxt;
      if (frame_tick) begin
        load_pending <= 1'b0;
      end else if (load) begin
        shadow_q     <= msg_in;
        load_pending <= 1'b1;
      end
      if (slot_tick) begin
        com <= COM_ACT_HIGH ? com_raw : ~com_raw;
        seg <= SEG_ACT_HIGH ? seg_raw : ~seg_raw;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed scoreboard bench for seg_scan_display: expected per-slot com/seg
// entries are queued with the stimulus and popped as each slot is displayed.
module tb_seg_scan_display;
  import seg_disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] msg_in = '0;
  logic [1:0]  mode = MODE_STATIC;
  logic [3:0]  com;
  logic [6:0]  seg;
  logic        load_pending;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;
  int ft_count = 0;

  typedef struct {
    string      tag;
    logic [3:0] com;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  seg_scan_display #(
    .NUM_DIGITS    (4),
    .PRESCALE      (4),
    .BLINK_FRAMES  (2),
    .SCROLL_FRAMES (2),
    .INIT_MSG      (16'hCBA0),
    .COM_ACT_HIGH  (1'b1),
    .SEG_ACT_HIGH  (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .msg_in       (msg_in),
    .mode         (mode),
    .com          (com),
    .seg          (seg),
    .load_pending (load_pending),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && frame_tick) ft_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    exp_t e;
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      e.tag = $sformatf("%s.slot%0d", tag, i);
      e.com = 4'b0001 << i;
      e.seg = s[i];
      sb.push_back(e);
    end
  endtask

  // Called 1 ns after a slot starts: compare, then run the slot's 4 clocks,
  // optionally pulsing load on clock load_at of the slot.
  task automatic slot(input int load_at = -1, input logic [15:0] msg = 16'h0000);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underrun", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".com"}, 32'(com), 32'(e.com));
      check({e.tag, ".seg"}, 32'(seg), 32'(e.seg));
    end
    msg_in = msg;
    for (int c = 0; c < 4; c++) begin
      load = (c == load_at);
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.com", 32'(com), 32'h1);
    check("reset.seg", 32'(seg), 32'h3F);
    check("reset.load_pending", 32'(load_pending), 32'h0);
    check("reset.frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Frames 0-1: static "OPEN"
    push_frame("open_f0", 7'h3F, 7'h73, 7'h79, 7'h54);
    push_frame("open_f1", 7'h3F, 7'h73, 7'h79, 7'h54);
    repeat (8) slot();
    check("frame_tick.count_2_frames", 32'(ft_count), 32'd2);

    // Frames 2-3: mid-frame load, committed at the frame boundary
    push_frame("preload_f2", 7'h3F, 7'h73, 7'h79, 7'h54);
    push_frame("msg1234_f3", 7'h66, 7'h4F, 7'h5B, 7'h06);
    slot();
    slot(1, 16'h1234);
    check("load1234.pending_set", 32'(load_pending), 32'h1);
    slot();
    slot();
    check("load1234.pending_clear", 32'(load_pending), 32'h0);
    repeat (4) slot();

    // Frames 4-6: last write wins, then load on the frame_tick cycle bypasses
    push_frame("twoload_f4", 7'h66, 7'h4F, 7'h5B, 7'h06);
    push_frame("msg2222_f5", 7'h5B, 7'h5B, 7'h5B, 7'h5B);
    push_frame("bypass_f6",  7'h4F, 7'h4F, 7'h4F, 7'h4F);
    slot(0, 16'h1111);
    slot();
    slot(2, 16'h2222);
    check("twoload.pending_set", 32'(load_pending), 32'h1);
    slot();
    check("twoload.pending_clear", 32'(load_pending), 32'h0);
    slot();
    slot();
    slot();
    slot(3, 16'h3333);
    check("bypass.pending_never_set", 32'(load_pending), 32'h0);
    slot();
    slot();
    slot();
    mode = MODE_BLINK;
    slot();

    // Frames 7-10: blink, off on 6-7 and 10-11, on 8-9
    push_frame("blink_off_f7", 7'h00, 7'h00, 7'h00, 7'h00);
    push_frame("blink_on_f8",  7'h4F, 7'h4F, 7'h4F, 7'h4F);
    push_frame("blink_on_f9",  7'h4F, 7'h4F, 7'h4F, 7'h4F);
    push_frame("blink_off_f10", 7'h00, 7'h00, 7'h00, 7'h00);
    repeat (12) slot();
    slot(1, 16'hCBA0);
    slot();
    slot();
    mode = MODE_SCROLL;
    slot();

    // Frames 11-15: scroll "OPEN", then back to static mid-frame
    push_frame("scroll0_f11", 7'h3F, 7'h73, 7'h79, 7'h54);
    push_frame("scroll0_f12", 7'h3F, 7'h73, 7'h79, 7'h54);
    push_frame("scroll1_f13", 7'h73, 7'h79, 7'h54, 7'h3F);
    push_frame("to_static_f14", 7'h73, 7'h79, 7'h79, 7'h54);
    push_frame("static_f15", 7'h3F, 7'h73, 7'h79, 7'h54);
    repeat (12) slot();
    slot();
    mode = MODE_STATIC;
    repeat (3) slot();
    repeat (4) slot();

    // Frame 16: reset mid-frame with a pending load
    push_frame("prereset_f16", 7'h3F, 7'h73, 7'h79, 7'h54);
    slot();
    slot(0, 16'h1234);
    check("prereset.pending_set", 32'(load_pending), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset.com", 32'(com), 32'h1);
    check("async_reset.seg", 32'(seg), 32'h3F);
    check("async_reset.load_pending", 32'(load_pending), 32'h0);
    check("async_reset.frame_tick", 32'(frame_tick), 32'h0);
    check("frame_tick.count_16_frames", 32'(ft_count), 32'd16);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    push_frame("after_reset", 7'h3F, 7'h73, 7'h79, 7'h54);
    repeat (4) slot();
    check("after_reset.pending", 32'(load_pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed 7-segment message scanner and the successor to the fixed 4-digit "OPEN" scanner. It time-multiplexes NUM_DIGITS common lines and shares one segment bus across them. It shows a loadable glyph message and supports static, blink, scroll and blank modes. It sits between the doorlock controller, which supplies message, load and mode, and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
PRESCALE, 1000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 64, scan frames per blink half-period (>=1)
SCROLL_FRAMES, 128, scan frames per scroll step (>=1)
INIT_MSG, 16'hCBA0, reset message, 4*NUM_DIGITS bits; default reads "OPEN"
COM_ACT_HIGH, 1, 1: active common = 1; 0: inverted
SEG_ACT_HIGH, 1, 1: lit segment = 1; 0: inverted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
load  in  1  one-cycle strobe; captures msg_in
msg_in  in  4*NUM_DIGITS  glyph codes; digit i = msg_in[4i+3:4i]; digit 0 = leftmost
mode  in  2  0 static, 1 blink, 2 scroll-left, 3 blank
com  out  NUM_DIGITS  one-hot digit enable; com[i] drives digit i
seg  out  7  segments, seg[0]=a … seg[6]=g
load_pending  out  1  high while a captured message waits for commit
frame_tick  out  1  one-cycle pulse at the last slot of each frame

Behaviour:
- Reset (rst=0, async) sets all state:
  - prescale count 0, digit index 0, frame counters 0, blink phase on, scroll offset 0.
  - Active message and shadow = INIT_MSG; load_pending 0, frame_tick 0.
  - com = digit 0 active; seg = glyph of INIT_MSG digit 0 in mode-0 rendering.
- Prescaler: counts 0..PRESCALE-1 and wraps. slot_tick is asserted when the count = PRESCALE-1.
- Digit index:
  - Advances on slot_tick and wraps NUM_DIGITS-1 -> 0.
  - frame_tick = slot_tick while the index = NUM_DIGITS-1.
- com and seg are registered and update on the same edge the index advances, so they always reflect the current index. Exactly one com is active at all times; it is never zero-hot.
- Load handshake:
  - load=1 captures msg_in into the shadow and sets load_pending.
  - Commit (shadow -> active, scroll offset -> 0, load_pending -> 0) happens on frame_tick, so the new message starts at digit 0 of the next frame. This gives no tearing.
  - Load while pending overwrites the shadow; last write wins.
  - Load on the frame_tick cycle commits msg_in directly; load_pending stays 0.
- Glyph table (4-bit code -> {g..a}):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
  - A(P):73 B(E):79 C(n):54 D(C):39 E(-):40 F(blank):00
- Mode rendering for slot i:
  - mode 0: glyph(active[i]).
  - mode 1: as mode 0 while blink phase on; seg off while phase off. com keeps scanning.
  - mode 2: glyph(active[(i+offset) mod NUM_DIGITS]).
  - mode 3: seg off, com scanning.
- Blink phase toggles every BLINK_FRAMES frames. The counter runs in all modes.
- Scroll:
  - Offset increments mod NUM_DIGITS every SCROLL_FRAMES frames, only while mode=2.
  - Offset clears to 0 when mode != 2 and on commit.
- mode is sampled every cycle. A change is visible from the next slot update; no glitch occurs mid-slot.
- Polarity parameters invert com/seg at the output registers only.
- Reset asserted mid-frame returns to the reset state immediately; any pending load is discarded.

Decomposition:
- Package seg_disp_pkg holds:
  - mode localparams: MODE_STATIC, MODE_BLINK, MODE_SCROLL, MODE_BLANK.
  - glyph code constants: GLY_P=4'hA, GLY_E, GLY_N, GLY_C, GLY_DASH, GLY_BLANK.
  - function glyph_to_seg.
- One sub-module, seg_scan_timer, holds the prescaler, digit index, frame counter, blink phase and scroll offset. It outputs slot_tick, frame_tick, index, blink_on and offset.

Test Plan:
Test-bench parameters: PRESCALE=4, BLINK_FRAMES=2, SCROLL_FRAMES=2.
- Reset release, mode 0:
  - com cycles 0001->0010->0100->1000 every 4 clk.
  - seg sequence 3F,73,79,54.
  - frame_tick pulses once per 16 clk.
- load msg_in=16'h1234 mid-frame:
  - load_pending=1 until frame_tick.
  - Next frame seg = 6D? No: digit0=4 -> 66, then 4F,5B,06.
  - load_pending=0 after commit.
- Two loads in one frame (16'h1111 then 16'h2222); load on the frame_tick cycle with 16'h3333 -> 5B-only frame for the first case; 4F-only next frame for the bypass case, load_pending never set.
- mode=1: seg=00 on frames 2-3, 6-7, … while com still scans; seg restored on frames 0-1, 4-5.
- mode=2 with "OPEN":
  - Frames 0-1 O,P,E,n; frames 2-3 P,E,n,O.
  - Switching mode to 0 restores O,P,E,n from the next slot.
- Assert rst mid-frame with a pending load: outputs return to the reset values asynchronously; message reads "OPEN" again.
